// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (also used by the execute-stage ALU),
// MIPS opcode/funct field values and decoder operand-select encodings.
package alu_pkg;

  // ALU op codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SL  = 4'd6;
  localparam logic [3:0] ALU_SR  = 4'd7;
  localparam logic [3:0] ALU_LT  = 4'd8;
  localparam logic [3:0] ALU_LE  = 4'd9;
  localparam logic [3:0] ALU_GT  = 4'd10;
  // Default code for undecodable instructions; the ALU returns 0 for it
  localparam logic [3:0] ALU_BAD_OP = 4'hF;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [2:0] {IN1_RS, IN1_SHAMT, IN1_RS5, IN1_C16, IN1_ZERO} in1_sel_e;
  typedef enum logic [1:0] {IN2_RT, IN2_SEXT, IN2_ZEXT, IN2_ZERO} in2_sel_e;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_NONE} dst_sel_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS decoder: opcode/funct -> ALU op, sign, operand selects,
// destination select, register-write intent and illegal flag.
// reg_write here is intent only; the top suppresses writes to register 0.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter logic [3:0] BAD_OP = ALU_BAD_OP
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       sign,
  output in1_sel_e   in1_sel,
  output in2_sel_e   in2_sel,
  output dst_sel_e   dst_sel,
  output logic       reg_write,
  output logic       illegal
);

  // Decode table; anything not listed falls back to the illegal defaults
  always_comb begin
    alu_ctrl  = BAD_OP;
    sign      = 1'b0;
    in1_sel   = IN1_ZERO;
    in2_sel   = IN2_ZERO;
    dst_sel   = DST_NONE;
    reg_write = 1'b0;
    illegal   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        in1_sel   = IN1_RS;
        in2_sel   = IN2_RT;
        dst_sel   = DST_RD;
        reg_write = 1'b1;
        illegal   = 1'b0;
        case (funct)
          F_ADD:  begin alu_ctrl = ALU_ADD; sign = 1'b1; end
          F_ADDU: alu_ctrl = ALU_ADD;
          F_SUB:  begin alu_ctrl = ALU_SUB; sign = 1'b1; end
          F_SUBU: alu_ctrl = ALU_SUB;
          F_AND:  alu_ctrl = ALU_AND;
          F_OR:   alu_ctrl = ALU_OR;
          F_XOR:  alu_ctrl = ALU_XOR;
          F_NOR:  alu_ctrl = ALU_NOR;
          F_SLT:  begin alu_ctrl = ALU_LT; sign = 1'b1; end
          F_SLTU: alu_ctrl = ALU_LT;
          F_SLL:  begin alu_ctrl = ALU_SL; in1_sel = IN1_SHAMT; end
          F_SRL:  begin alu_ctrl = ALU_SR; in1_sel = IN1_SHAMT; end
          F_SRA:  begin alu_ctrl = ALU_SR; in1_sel = IN1_SHAMT; sign = 1'b1; end
          F_SLLV: begin alu_ctrl = ALU_SL; in1_sel = IN1_RS5; end
          F_SRLV: begin alu_ctrl = ALU_SR; in1_sel = IN1_RS5; end
          F_SRAV: begin alu_ctrl = ALU_SR; in1_sel = IN1_RS5; sign = 1'b1; end
          default: begin
            alu_ctrl  = BAD_OP;
            in1_sel   = IN1_ZERO;
            in2_sel   = IN2_ZERO;
            dst_sel   = DST_NONE;
            reg_write = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI:  begin alu_ctrl = ALU_ADD; sign = 1'b1; in1_sel = IN1_RS; in2_sel = IN2_SEXT;
                      dst_sel = DST_RT; reg_write = 1'b1; illegal = 1'b0; end
      OP_ADDIU: begin alu_ctrl = ALU_ADD; in1_sel = IN1_RS; in2_sel = IN2_SEXT;
                      dst_sel = DST_RT; reg_write = 1'b1; illegal = 1'b0; end
      OP_SLTI:  begin alu_ctrl = ALU_LT; sign = 1'b1; in1_sel = IN1_RS; in2_sel = IN2_SEXT;
                      dst_sel = DST_RT; reg_write = 1'b1; illegal = 1'b0; end
      OP_SLTIU: begin alu_ctrl = ALU_LT; in1_sel = IN1_RS; in2_sel = IN2_SEXT;
                      dst_sel = DST_RT; reg_write = 1'b1; illegal = 1'b0; end
      OP_ANDI:  begin alu_ctrl = ALU_AND; in1_sel = IN1_RS; in2_sel = IN2_ZEXT;
                      dst_sel = DST_RT; reg_write = 1'b1; illegal = 1'b0; end
      OP_ORI:   begin alu_ctrl = ALU_OR; in1_sel = IN1_RS; in2_sel = IN2_ZEXT;
                      dst_sel = DST_RT; reg_write = 1'b1; illegal = 1'b0; end
      OP_XORI:  begin alu_ctrl = ALU_XOR; in1_sel = IN1_RS; in2_sel = IN2_ZEXT;
                      dst_sel = DST_RT; reg_write = 1'b1; illegal = 1'b0; end
      // lui is imm << 16, so the shift amount is the constant 16
      OP_LUI:   begin alu_ctrl = ALU_SL; in1_sel = IN1_C16; in2_sel = IN2_ZEXT;
                      dst_sel = DST_RT; reg_write = 1'b1; illegal = 1'b0; end
      // Loads/stores only need the effective address rs + sext(imm)
      OP_LW:    begin alu_ctrl = ALU_ADD; in1_sel = IN1_RS; in2_sel = IN2_SEXT;
                      dst_sel = DST_RT; reg_write = 1'b1; illegal = 1'b0; end
      OP_SW:    begin alu_ctrl = ALU_ADD; in1_sel = IN1_RS; in2_sel = IN2_SEXT;
                      illegal = 1'b0; end
      OP_BEQ,
      OP_BNE:   begin alu_ctrl = ALU_SUB; in1_sel = IN1_RS; in2_sel = IN2_RT; illegal = 1'b0; end
      // blez/bgtz compare rs against zero as a signed value
      OP_BLEZ:  begin alu_ctrl = ALU_LE; sign = 1'b1; in1_sel = IN1_RS; illegal = 1'b0; end
      OP_BGTZ:  begin alu_ctrl = ALU_GT; sign = 1'b1; in1_sel = IN1_RS; illegal = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes the instruction, builds ALU operands and holds
// them in the EX pipeline register behind a valid/ready handshake.
// Optional feature macro: ALU_ISSUE_FWD_EN adds EX/MEM result forwarding
// onto the rs/rt read data (EX has priority, register 0 never forwarded).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter int         REG_W  = 5,
  parameter logic [3:0] BAD_OP = ALU_BAD_OP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
`ifdef ALU_ISSUE_FWD_EN
  input  logic              fwd_ex_we,
  input  logic [REG_W-1:0]  fwd_ex_dst,
  input  logic [DATA_W-1:0] fwd_ex_data,
  input  logic              fwd_mem_we,
  input  logic [REG_W-1:0]  fwd_mem_dst,
  input  logic [DATA_W-1:0] fwd_mem_data,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_ctrl,
  output logic              out_sign,
  output logic [DATA_W-1:0] out_in1,
  output logic [DATA_W-1:0] out_in2,
  output logic [REG_W-1:0]  out_dst,
  output logic              out_reg_write,
  output logic              out_illegal
);

  logic [3:0]  dec_ctrl;
  logic        dec_sign, dec_we, dec_ill;
  in1_sel_e    dec_in1_sel;
  in2_sel_e    dec_in2_sel;
  dst_sel_e    dec_dst_sel;

  logic [REG_W-1:0]         rs_idx, rt_idx;
  logic [DATA_W-1:0]        rs_val, rt_val;
  logic signed [DATA_W-1:0] imm_sext;

  logic              valid_d, valid_q, sign_d, sign_q, we_d, we_q, ill_d, ill_q;
  logic [3:0]        ctrl_d, ctrl_q;
  logic [DATA_W-1:0] in1_d, in1_q, in2_d, in2_q;
  logic [REG_W-1:0]  dst_d, dst_q, dst_new;
  logic              xfer;

  alu_ctrl_decode #(.BAD_OP(BAD_OP)) u_dec (
    .opcode    (in_instr[31:26]),
    .funct     (in_instr[5:0]),
    .alu_ctrl  (dec_ctrl),
    .sign      (dec_sign),
    .in1_sel   (dec_in1_sel),
    .in2_sel   (dec_in2_sel),
    .dst_sel   (dec_dst_sel),
    .reg_write (dec_we),
    .illegal   (dec_ill)
  );

  assign rs_idx   = REG_W'(in_instr[25:21]);
  assign rt_idx   = REG_W'(in_instr[20:16]);
  assign imm_sext = DATA_W'($signed(in_instr[15:0]));

`ifdef ALU_ISSUE_FWD_EN
  function automatic logic [DATA_W-1:0] fwd_pick(input logic [REG_W-1:0] idx,
                                                 input logic [DATA_W-1:0] raw,
                                                 input logic ex_we, input logic [REG_W-1:0] ex_dst,
                                                 input logic [DATA_W-1:0] ex_data,
                                                 input logic mem_we, input logic [REG_W-1:0] mem_dst,
                                                 input logic [DATA_W-1:0] mem_data);
    if (idx == '0)                        return raw;
    else if (ex_we && ex_dst == idx)      return ex_data;
    else if (mem_we && mem_dst == idx)    return mem_data;
    else                                  return raw;
  endfunction

  assign rs_val = fwd_pick(rs_idx, in_rs_data, fwd_ex_we, fwd_ex_dst, fwd_ex_data,
                           fwd_mem_we, fwd_mem_dst, fwd_mem_data);
  assign rt_val = fwd_pick(rt_idx, in_rt_data, fwd_ex_we, fwd_ex_dst, fwd_ex_data,
                           fwd_mem_we, fwd_mem_dst, fwd_mem_data);
`else
  logic unused_rs_idx;
  assign unused_rs_idx = ^rs_idx;
  assign rs_val = in_rs_data;
  assign rt_val = in_rt_data;
`endif

  assign in_ready = !valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  // Next-state: handshake for valid, operand/dst muxing and load-or-hold for payload
  always_comb begin
    dst_new = '0;
    case (dec_dst_sel)
      DST_RD:  dst_new = REG_W'(in_instr[15:11]);
      DST_RT:  dst_new = rt_idx;
      default: dst_new = '0;
    endcase

    if (flush)          valid_d = 1'b0;
    else if (xfer)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    else                valid_d = valid_q;

    ctrl_d = ctrl_q;
    sign_d = sign_q;
    in1_d  = in1_q;
    in2_d  = in2_q;
    dst_d  = dst_q;
    we_d   = we_q;
    ill_d  = ill_q;
    if (xfer) begin
      ctrl_d = dec_ctrl;
      sign_d = dec_sign;
      dst_d  = dst_new;
      we_d   = dec_we && (dst_new != '0);
      ill_d  = dec_ill;
      case (dec_in1_sel)
        IN1_RS:    in1_d = rs_val;
        IN1_SHAMT: in1_d = DATA_W'(in_instr[10:6]);
        IN1_RS5:   in1_d = DATA_W'(rs_val[4:0]);
        IN1_C16:   in1_d = DATA_W'(16);
        default:   in1_d = '0;
      endcase
      case (dec_in2_sel)
        IN2_RT:   in2_d = rt_val;
        IN2_SEXT: in2_d = imm_sext;
        IN2_ZEXT: in2_d = DATA_W'(in_instr[15:0]);
        default:  in2_d = '0;
      endcase
    end
  end

  // EX pipeline register; reset clears the whole bundle
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      sign_q  <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      dst_q   <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      sign_q  <= sign_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      dst_q   <= dst_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_alu_ctrl  = ctrl_q;
  assign out_sign      = sign_q;
  assign out_in1       = in1_q;
  assign out_in2       = in2_q;
  assign out_dst       = dst_q;
  assign out_reg_write = we_q;
  assign out_illegal   = ill_q;

endmodule
